// File: rtl/phase_pkg.sv
// Shared definitions for blocks that consume the 0..5759 phase-index stream
// (1/16 degree per step, 5760 steps per electrical turn).
package phase_pkg;

  localparam int PHASE_STEPS = 5760;
  localparam int PHASE_W     = 16;
  localparam logic [PHASE_W-1:0] PHASE_MAX = 16'd5759;

  typedef enum logic [1:0] {
    STEP_NONE   = 2'b00,
    STEP_FWD    = 2'b01,
    STEP_REV    = 2'b10,
    STEP_GLITCH = 2'b11
  } step_e;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_ARM     = 2'b01,
    ST_MEASURE = 2'b10
  } meter_state_e;

  function automatic logic signed [15:0] sat16(input logic signed [17:0] v);
    if (v > 18'sd32767) begin
      return 16'sh7fff;
    end else if (v < -18'sd32768) begin
      return 16'sh8000;
    end else begin
      return v[15:0];
    end
  endfunction

endpackage

// File: rtl/phase_step_decoder.sv
// Registered classifier: turns a (phase, prev_phase) pair into a single-step
// code, treating the 5759<->0 seam as an ordinary +/-1 step.
module phase_step_decoder
  import phase_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic [PHASE_W-1:0] phase,
  input  logic [PHASE_W-1:0] prev_phase,
  input  logic               valid,
  output step_e              step
);

  localparam logic signed [PHASE_W:0] WRAP = $signed({1'b0, PHASE_MAX});

  logic signed [PHASE_W:0] delta;
  step_e                   step_next;

  always_comb begin
    delta     = $signed({1'b0, phase}) - $signed({1'b0, prev_phase});
    step_next = STEP_NONE;
    if (valid) begin
      if (phase > PHASE_MAX) begin
        step_next = STEP_GLITCH;
      end else if (delta == '0) begin
        step_next = STEP_NONE;
      end else if (delta == 17'sd1 || delta == -WRAP) begin
        step_next = STEP_FWD;
      end else if (delta == -17'sd1 || delta == WRAP) begin
        step_next = STEP_REV;
      end else begin
        step_next = STEP_GLITCH;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      step <= STEP_NONE;
    end else begin
      step <= step_next;
    end
  end

endmodule

// File: rtl/phase_freq_meter.sv
// Gate-window frequency meter for the phase-index stream: counts signed
// single steps per window and reports 0.1 Hz units, plus stall/error flags.
module phase_freq_meter
  import phase_pkg::*;
#(
  parameter int GATE_CYCLES  = 69444,
  parameter int STALL_CYCLES = 1000000
) (
  input  logic               clk_40_mhz,
  input  logic               reset_n,
  input  logic               enable,
  input  logic [PHASE_W-1:0] phase,
  output logic signed [15:0] freq_est,
  output logic               freq_valid,
  output logic               direction,
  output logic               stalled,
  output logic               phase_err,
  output meter_state_e       fsm_state
);

  localparam int GATE_W  = $clog2(GATE_CYCLES);
  localparam int STALL_W = $clog2(STALL_CYCLES + 1);
  localparam logic [GATE_W-1:0]  GATE_LAST = GATE_W'(GATE_CYCLES - 1);
  localparam logic [STALL_W-1:0] STALL_MAX = STALL_W'(STALL_CYCLES);

  meter_state_e       state;
  logic [PHASE_W-1:0] prev_phase;
  logic               dec_valid;
  logic               step_valid;
  step_e              step_code;
  logic               counted;
  logic signed [16:0] acc;
  logic signed [17:0] acc_sum;
  logic [GATE_W-1:0]  gate_cnt;
  logic [STALL_W-1:0] stall_cnt;

  assign fsm_state = state;
  assign dec_valid = enable && (state == ST_MEASURE);

  phase_step_decoder u_decoder (
    .clk        (clk_40_mhz),
    .rst_n      (reset_n),
    .phase      (phase),
    .prev_phase (prev_phase),
    .valid      (dec_valid),
    .step       (step_code)
  );

  // acc_sum includes the step landing this cycle, so a step on the gate
  // terminal cycle still belongs to the window being closed.
  always_comb begin
    counted = step_valid && (step_code == STEP_FWD || step_code == STEP_REV);
    acc_sum = {acc[16], acc};
    if (counted) begin
      acc_sum = (step_code == STEP_FWD) ? acc_sum + 18'sd1 : acc_sum - 18'sd1;
    end
  end

  // freq_valid is a one-cycle strobe: freq_est is only meaningful to a
  // consumer on the cycle freq_valid is high; there is no back-pressure.
  always_ff @(posedge clk_40_mhz or negedge reset_n) begin
    if (!reset_n) begin
      state      <= ST_IDLE;
      prev_phase <= '0;
      step_valid <= 1'b0;
      acc        <= '0;
      gate_cnt   <= '0;
      stall_cnt  <= '0;
      freq_est   <= '0;
      freq_valid <= 1'b0;
      direction  <= 1'b0;
      stalled    <= 1'b0;
      phase_err  <= 1'b0;
    end else if (!enable) begin
      state      <= ST_IDLE;
      prev_phase <= '0;
      step_valid <= 1'b0;
      acc        <= '0;
      gate_cnt   <= '0;
      stall_cnt  <= '0;
      freq_est   <= '0;
      freq_valid <= 1'b0;
      direction  <= 1'b0;
      stalled    <= 1'b0;
      phase_err  <= 1'b0;
    end else begin
      freq_valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          state <= ST_ARM;
        end
        ST_ARM: begin
          prev_phase <= phase;
          state      <= ST_MEASURE;
        end
        ST_MEASURE: begin
          prev_phase <= phase;
          step_valid <= 1'b1;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase

      if (step_valid) begin
        if (gate_cnt == GATE_LAST) begin
          gate_cnt   <= '0;
          acc        <= '0;
          freq_est   <= sat16(acc_sum);
          freq_valid <= 1'b1;
        end else begin
          gate_cnt <= gate_cnt + 1'b1;
          acc      <= acc_sum[16:0];
        end

        // The stall report is written after the gate update so it wins
        // when both land on the same cycle.
        if (counted) begin
          stall_cnt <= '0;
          stalled   <= 1'b0;
          direction <= (step_code == STEP_FWD);
        end else if (stall_cnt != STALL_MAX) begin
          stall_cnt <= stall_cnt + 1'b1;
          if (stall_cnt == STALL_MAX - 1'b1) begin
            stalled    <= 1'b1;
            freq_est   <= '0;
            freq_valid <= 1'b1;
          end
        end

        if (step_code == STEP_GLITCH) begin
          phase_err <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_phase_freq_meter.sv
// Bench for phase_freq_meter with shortened gate/stall windows: a window-level
// reference model checked every cycle, plus literal expectations per scenario.
module tb_phase_freq_meter;
  import phase_pkg::*;

  localparam int G = 500;
  localparam int S = 1200;

  // clock / reset
  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic               enable = 1'b0;
  logic [15:0]        phase  = '0;
  logic signed [15:0] freq_est;
  logic               freq_valid;
  logic               direction;
  logic               stalled;
  logic               phase_err;
  meter_state_e       fsm_state;

  phase_freq_meter #(.GATE_CYCLES(G), .STALL_CYCLES(S)) dut (
    .clk_40_mhz (clk),
    .reset_n    (rst_n),
    .enable     (enable),
    .phase      (phase),
    .freq_est   (freq_est),
    .freq_valid (freq_valid),
    .direction  (direction),
    .stalled    (stalled),
    .phase_err  (phase_err),
    .fsm_state  (fsm_state)
  );

  int vectors     = 0;
  int miscompares = 0;

  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // reference model: steps per window from the spec rules
  int m_t = -1;
  int m_prev = 0;
  int m_pend = 0;
  bit m_pend_v = 0;
  int win_q[$];
  int stall_run = 0;
  int m_sum;
  bit m_reached;
  int e_freq = 0;
  bit e_valid = 0, e_dir = 0, e_stalled = 0, e_err = 0;

  function automatic int classify(input int cur, input int prv);
    int d;
    if (cur > 5759) return 2;
    d = cur - prv;
    if (d == 0) return 0;
    if (d == 1 || d == -5759) return 1;
    if (d == -1 || d == 5759) return -1;
    return 2;
  endfunction

  function automatic int sat(input int v);
    if (v > 32767) return 32767;
    if (v < -32768) return -32768;
    return v;
  endfunction

  task automatic model_clear();
    m_t = -1; m_pend_v = 0; win_q.delete(); stall_run = 0;
    e_freq = 0; e_valid = 0; e_dir = 0; e_stalled = 0; e_err = 0;
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n || !enable) begin
      model_clear();
    end else begin
      m_t++;
      e_valid = 0;
      if (m_pend_v) begin
        m_reached = 0;
        if (m_pend == 2) e_err = 1;
        if (m_pend == 1 || m_pend == -1) begin
          win_q.push_back(m_pend);
          e_dir = (m_pend == 1);
          stall_run = 0;
        end else begin
          win_q.push_back(0);
          if (stall_run < S) begin
            stall_run++;
            m_reached = (stall_run == S);
          end
        end
        if (win_q.size() == G) begin
          m_sum = 0;
          foreach (win_q[i]) m_sum += win_q[i];
          e_freq = sat(m_sum);
          e_valid = 1;
          win_q.delete();
        end
        if (m_reached) begin
          e_freq = 0;
          e_valid = 1;
        end
        e_stalled = (stall_run == S);
      end
      m_pend_v = 0;
      if (m_t >= 2) begin
        m_pend = classify(int'(phase), m_prev);
        m_pend_v = 1;
      end
      if (m_t >= 1) m_prev = int'(phase);
    end
  end

  // scoreboard: every cycle, away from the active edge
  always @(negedge clk) begin
    check("freq_est", int'(freq_est), e_freq);
    check("freq_valid", int'(freq_valid), int'(e_valid));
    check("direction", int'(direction), int'(e_dir));
    check("stalled", int'(stalled), int'(e_stalled));
    check("phase_err", int'(phase_err), int'(e_err));
  end

  int last_freq = 0;
  int pulses = 0;
  always @(negedge clk) begin
    if (freq_valid === 1'b1) begin
      last_freq = int'(freq_est);
      pulses++;
    end
  end

  // driver tasks
  int cur_ph = 0;

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic run_steps(input int dir, input int period, input int cycles);
    for (int i = 0; i < cycles; i++) begin
      tick();
      if ((i % period) == period - 1) cur_ph = (cur_ph + dir + 5760) % 5760;
      phase = 16'(cur_ph);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_freq_est"}, int'(freq_est), 0);
    check({tag, "_freq_valid"}, int'(freq_valid), 0);
    check({tag, "_direction"}, int'(direction), 0);
    check({tag, "_stalled"}, int'(stalled), 0);
    check({tag, "_phase_err"}, int'(phase_err), 0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, p0, mode, len, per;
    bit got;
    #1 rst_n = 1'b0;
    repeat (3) tick();
    check_all_zero("reset");
    check("reset_state", int'(fsm_state), int'(ST_IDLE));
    rst_n = 1'b1;
    tick();

    // forward, one step per 10 clocks, across 5759->0
    cur_ph = 5740;
    phase  = 16'(cur_ph);
    enable = 1'b1;
    run_steps(1, 10, 4 * G);
    check("fwd_freq", last_freq, 50);
    check("fwd_dir", int'(direction), 1);
    check("fwd_no_err", int'(phase_err), 0);

    // reverse, one step per 5 clocks, across 0->5759
    run_steps(-1, 5, 3 * G);
    check("rev_freq", last_freq, -100);
    check("rev_dir", int'(direction), 0);
    check("rev_no_err", int'(phase_err), 0);

    // jump, illegal sample, resync to a legal value
    tick();
    cur_ph = (cur_ph + 200) % 5760;
    phase  = 16'(cur_ph);
    run_steps(0, 1, 20);
    for (int i = 0; i < 20; i++) begin
      tick();
      phase = 16'd6000;
    end
    cur_ph = 300;
    run_steps(1, 10, 2 * G);
    check("glitch_err_sticky", int'(phase_err), 1);
    check("glitch_resume_freq", last_freq, 50);

    // stall
    run_steps(0, 1, S + 100);
    check("stall_flag", int'(stalled), 1);
    check("stall_freq", int'(freq_est), 0);
    run_steps(1, 1, 1);
    run_steps(0, 1, 5);
    check("stall_clear", int'(stalled), 0);
    check("stall_clear_dir", int'(direction), 1);

    // randomized segments
    for (int seg = 0; seg < 16; seg++) begin
      mode = int'($urandom_range(0, 4));
      len  = int'($urandom_range(100, 600));
      per  = int'($urandom_range(1, 40));
      case (mode)
        0: run_steps(1, per, len);
        1: run_steps(-1, per, len);
        2: run_steps(0, 1, len);
        3: begin
          if ($urandom_range(0, 1) == 1) begin
            tick();
            phase = 16'($urandom_range(5760, 65535));
          end
          cur_ph = int'($urandom_range(0, 5759));
          run_steps(1, per, len);
        end
        default: begin
          tick();
          enable = 1'b0;
          repeat (int'($urandom_range(1, 5))) tick();
          enable = 1'b1;
          run_steps(1, per, len);
        end
      endcase
    end

    // enable drop mid-window, then restart latency
    run_steps(1, 10, 250);
    tick();
    enable = 1'b0;
    p0 = pulses;
    tick();
    check_all_zero("disable");
    run_steps(0, 1, 10);
    check("disable_no_pulse", pulses, p0);
    enable = 1'b1;
    n = 0;
    got = 0;
    while (!got && n < 3 * G) begin
      @(posedge clk);
      n++;
      @(negedge clk);
      if (freq_valid === 1'b1) got = 1;
    end
    check("restart_latency", n, G + 3);

    // asynchronous reset mid-window
    run_steps(1, 10, 200);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check_all_zero("async_reset");
    check("async_reset_state", int'(fsm_state), int'(ST_IDLE));
    tick();
    tick();
    rst_n = 1'b1;
    run_steps(1, 10, 2 * G + 200);
    check("post_reset_freq", last_freq, 50);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
